// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad. One column is driven low at a time.
//   The row inputs are synchronised into the clock domain and debounced, and
//   each accepted press is encoded as row*4 + col. The one-cycle key_valid
//   strobe enables the downstream operand/digit latches, and key_code feeds
//   their data inputs.
//
// Parameters
//   SCAN_DIV      clock cycles each column is driven before advancing (>= 4)
//   DEBOUNCE_CNT  consecutive stable cycles needed to accept a press or a
//                 release (>= 2)
//
// Ports
//   clk        system clock, rising edge
//   rstn       synchronous active-low reset
//   row_in     keypad rows, active-low, pulled up, asynchronous to clk
//   col_out    column drive, active-low, exactly one bit low
//   key_code   code of the last accepted key, held until the next press
//   key_valid  one-cycle pulse when a press is accepted
//   key_held   high from acceptance until the debounced release
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 200000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  // Each counter only ever holds 0..N-1, so clog2(N) bits are always enough.
  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam int unsigned BW = $clog2(DEBOUNCE_CNT);

  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CNT - 1);
  localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
  localparam logic [BW-1:0] DEB_ONE    = BW'(1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_t;

  state_t        state;
  logic [3:0]    sync1;
  logic [3:0]    rs;
  logic [1:0]    col_idx;
  logic [DW-1:0] dwell;
  logic [BW-1:0] cnt;
  logic [1:0]    row_cap;
  logic [1:0]    low_row;
  logic          row_bit;

  // Lowest-numbered low row wins when several keys share a column.
  always_comb begin
    casez (rs)
      4'b???0: low_row = 2'd0;
      4'b??01: low_row = 2'd1;
      4'b?011: low_row = 2'd2;
      default: low_row = 2'd3;
    endcase
  end

  // Synchronised level of the row that belongs to the captured key.
  always_comb begin
    row_bit = rs[row_cap];
  end

  // col_out is kept as its own register and rotated in lockstep with col_idx,
  // so it always equals ~(1 << col_idx) but drives the pins straight from
  // flops instead of through a decoder.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1     <= '1;
      rs        <= '1;
      state     <= SCAN;
      col_idx   <= '0;
      col_out   <= 4'b1110;
      dwell     <= '0;
      cnt       <= '0;
      row_cap   <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      sync1     <= row_in;
      rs        <= sync1;
      key_valid <= 1'b0;

      unique case (state)
        // Rows are only looked at on the last dwell cycle, which lets the
        // synchroniser settle after every column change.
        SCAN: begin
          if (dwell == DWELL_LAST) begin
            dwell <= '0;
            if (rs == 4'b1111) begin
              col_idx <= col_idx + 2'd1;
              col_out <= {col_out[2:0], col_out[3]};
            end else begin
              row_cap <= low_row;
              cnt     <= '0;
              state   <= DEBOUNCE;
            end
          end else begin
            dwell <= dwell + DWELL_ONE;
          end
        end

        // Column stays frozen; any high sample abandons the press.
        DEBOUNCE: begin
          if (row_bit) begin
            state   <= SCAN;
            dwell   <= '0;
            col_idx <= col_idx + 2'd1;
            col_out <= {col_out[2:0], col_out[3]};
          end else if (cnt == DEB_LAST) begin
            key_code  <= {row_cap, col_idx};
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            cnt       <= '0;
            state     <= HELD;
          end else begin
            cnt <= cnt + DEB_ONE;
          end
        end

        // Only the captured row is watched, so other keys pressed meanwhile
        // are invisible until scanning resumes.
        HELD: begin
          if (!row_bit) begin
            cnt <= '0;
          end else if (cnt == DEB_LAST) begin
            key_held <= 1'b0;
            cnt      <= '0;
            dwell    <= '0;
            state    <= SCAN;
            col_idx  <= col_idx + 2'd1;
            col_out  <= {col_out[2:0], col_out[3]};
          end else begin
            cnt <= cnt + DEB_ONE;
          end
        end

        default: begin
          state <= SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys = '0;

  int passed = 0;
  int total  = 0;
  int pulses = 0;

  keypad_scanner #(
    .SCAN_DIV    (4),
    .DEBOUNCE_CNT(8)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row_in = 4'b1111;
    for (int unsigned r = 0; r < 4; r++)
      for (int unsigned c = 0; c < 4; c++)
        if (keys[r*4+c] && (col_out[c] == 1'b0)) row_in[r] = 1'b0;
  end

  // Counts cycles in which key_valid was high.
  always @(posedge clk) if (key_valid === 1'b1) pulses++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Returns in the middle of cycle 0 after reset, with dwell 0 on column 0.
  task automatic do_reset();
    keys = '0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Steps negedges until key_valid is seen or limit is reached.
  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (key_valid !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    keys = '0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (col_out !== 4'b1110) $display("FAIL reset_col: got %b expected 1110", col_out); else passed++;
    total++; if (key_code !== 4'd0) $display("FAIL reset_code: got %0d expected 0", key_code); else passed++;
    total++; if (key_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", key_valid); else passed++;
    total++; if (key_held !== 1'b0) $display("FAIL reset_held: got %b expected 0", key_held); else passed++;
    rstn = 1'b1;
  endtask

  task automatic test_rotation();
    logic [3:0] e;
    int base;
    do_reset();
    base = pulses;
    for (int unsigned t = 0; t < 32; t++) begin
      e = 4'b1111;
      e[(t/4)%4] = 1'b0;
      total++; if (col_out !== e) $display("FAIL rotate_col t=%0d: got %b expected %b", t, col_out, e); else passed++;
      @(negedge clk);
    end
    total++; if (pulses != base) $display("FAIL rotate_novalid: got %0d pulses expected 0", pulses - base); else passed++;
  endtask

  task automatic test_clean_press();
    int base;
    int n;
    do_reset();
    base = pulses;
    keys[9] = 1'b1;
    wait_valid(40, n);
    total++; if (n != 16) $display("FAIL clean_latency: got %0d expected 16", n); else passed++;
    total++; if (key_code !== 4'd9) $display("FAIL clean_code: got %0d expected 9", key_code); else passed++;
    total++; if (key_held !== 1'b1) $display("FAIL clean_held_set: got %b expected 1", key_held); else passed++;
    @(negedge clk);
    total++; if (key_valid !== 1'b0) $display("FAIL clean_one_cycle: got %b expected 0", key_valid); else passed++;
    repeat (33) @(negedge clk);
    total++; if (key_held !== 1'b1) $display("FAIL clean_held_hold: got %b expected 1", key_held); else passed++;
    total++; if (pulses - base != 1) $display("FAIL clean_pulses_held: got %0d expected 1", pulses - base); else passed++;
    keys[9] = 1'b0;
    repeat (9) @(negedge clk);
    total++; if (key_held !== 1'b1) $display("FAIL clean_release_early: got %b expected 1", key_held); else passed++;
    @(negedge clk);
    total++; if (key_held !== 1'b0) $display("FAIL clean_release: got %b expected 0", key_held); else passed++;
    total++; if (col_out !== 4'b1011) $display("FAIL clean_resume_col: got %b expected 1011", col_out); else passed++;
    total++; if (key_code !== 4'd9) $display("FAIL clean_code_kept: got %0d expected 9", key_code); else passed++;
    total++; if (pulses - base != 1) $display("FAIL clean_pulses_total: got %0d expected 1", pulses - base); else passed++;
  endtask

  task automatic test_reset_mid_held();
    int base;
    int n;
    do_reset();
    keys[0] = 1'b1;
    wait_valid(40, n);
    total++; if (n != 12) $display("FAIL rsthold_first_latency: got %0d expected 12", n); else passed++;
    repeat (5) @(negedge clk);
    total++; if (key_held !== 1'b1) $display("FAIL rsthold_held: got %b expected 1", key_held); else passed++;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    base = pulses;
    total++; if (col_out !== 4'b1110) $display("FAIL rsthold_col: got %b expected 1110", col_out); else passed++;
    total++; if (key_code !== 4'd0) $display("FAIL rsthold_code: got %0d expected 0", key_code); else passed++;
    total++; if (key_held !== 1'b0) $display("FAIL rsthold_held_clr: got %b expected 0", key_held); else passed++;
    total++; if (key_valid !== 1'b0) $display("FAIL rsthold_valid: got %b expected 0", key_valid); else passed++;
    wait_valid(40, n);
    total++; if (n != 12) $display("FAIL rsthold_redetect: got %0d expected 12", n); else passed++;
    repeat (4) @(negedge clk);
    total++; if (pulses - base != 1) $display("FAIL rsthold_pulses: got %0d expected 1", pulses - base); else passed++;
  endtask

  task automatic test_bounce();
    int base;
    int n;
    do_reset();
    base = pulses;
    for (int unsigned i = 0; i < 40; i++) begin
      keys[12] = ((i/3)%2 == 0);
      @(negedge clk);
    end
    total++; if (pulses != base) $display("FAIL bounce_quiet: got %0d pulses expected 0", pulses - base); else passed++;
    keys[12] = 1'b1;
    wait_valid(80, n);
    total++; if (key_valid !== 1'b1) $display("FAIL bounce_accept: got %b expected 1", key_valid); else passed++;
    total++; if (key_code !== 4'd12) $display("FAIL bounce_code: got %0d expected 12", key_code); else passed++;
    repeat (5) @(negedge clk);
    total++; if (pulses - base != 1) $display("FAIL bounce_pulses: got %0d expected 1", pulses - base); else passed++;
  endtask

  task automatic test_two_keys();
    int base;
    int n;
    do_reset();
    base = pulses;
    keys[4]  = 1'b1;
    keys[12] = 1'b1;
    wait_valid(40, n);
    total++; if (n != 12) $display("FAIL twokey_latency: got %0d expected 12", n); else passed++;
    total++; if (key_code !== 4'd4) $display("FAIL twokey_code: got %0d expected 4", key_code); else passed++;
    repeat (20) @(negedge clk);
    total++; if (pulses - base != 1) $display("FAIL twokey_pulses: got %0d expected 1", pulses - base); else passed++;
  endtask

  task automatic test_second_key();
    int base;
    int n;
    do_reset();
    base = pulses;
    keys[0] = 1'b1;
    wait_valid(40, n);
    total++; if (n != 12) $display("FAIL second_first_latency: got %0d expected 12", n); else passed++;
    repeat (2) @(negedge clk);
    keys[15] = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (pulses - base != 1) $display("FAIL second_ignored: got %0d pulses expected 1", pulses - base); else passed++;
    total++; if (key_code !== 4'd0) $display("FAIL second_code_held: got %0d expected 0", key_code); else passed++;
    keys[0] = 1'b0;
    wait_valid(60, n);
    total++; if (n != 30) $display("FAIL second_latency: got %0d expected 30", n); else passed++;
    total++; if (key_code !== 4'd15) $display("FAIL second_code: got %0d expected 15", key_code); else passed++;
    repeat (4) @(negedge clk);
    total++; if (pulses - base != 2) $display("FAIL second_pulses: got %0d expected 2", pulses - base); else passed++;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_clean_press();
    test_reset_mid_held();
    test_bounce();
    test_two_keys();
    test_second_key();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
